// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execution unit: operation codes used by the
// ALU control decoder, the control FSM encoding and the result bundle.
package alu_exec_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD    = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB    = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND    = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR     = 6'b100101;
  localparam logic [OP_W-1:0] OP_NOR    = 6'b100111;
  localparam logic [OP_W-1:0] OP_XOR    = 6'b100110;
  localparam logic [OP_W-1:0] OP_SLL    = 6'b000000;
  localparam logic [OP_W-1:0] OP_SRL    = 6'b000010;
  localparam logic [OP_W-1:0] OP_SLT    = 6'b101010;
  localparam logic [OP_W-1:0] OP_JR     = 6'b001000;
  localparam logic [OP_W-1:0] OP_MUL    = 6'b011000;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE    = 6'b000101;
  localparam logic [OP_W-1:0] OP_BGTZ   = 6'b000111;
  localparam logic [OP_W-1:0] OP_BLEZ   = 6'b000110;
  localparam logic [OP_W-1:0] OP_REGIMM = 6'b000001;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] result;
    logic        branch;
    logic        illegal;
  } alu_out_t;

endpackage

// File: rtl/alu_exec_mult_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, 32 iterations,
// low 32 bits of the product. The final iteration is presented combinationally.
module mult_iter
  import alu_exec_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        done,
  output logic [31:0] P
);

  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic [31:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
  assign done      = r_busy && (r_cnt == 6'd31);
  assign P         = w_acc_nxt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_busy <= 1'b0;
      r_cnt  <= 6'd0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= 6'd0;
    end else if (r_busy) begin
      if (r_cnt == 6'd31) begin
        r_busy <= 1'b0;
        r_cnt  <= 6'd0;
      end else begin
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

  // Datapath registers carry no reset; r_busy qualifies them.
  always_ff @(posedge Clk) begin
    if (start) begin
      r_mcand  <= A;
      r_mplier <= B;
      r_acc    <= 32'd0;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: single-cycle ALU/branch operations plus a 33-cycle
// iterative multiply, with a valid/ready handshake on both sides.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [5:0]  ALUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Shamt,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        BranchTaken,
  output logic        Illegal
);

  function automatic alu_out_t alu_op(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] sh);
    alu_out_t          r;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa        = a;
    sb        = b;
    r.result  = 32'd0;
    r.branch  = 1'b0;
    r.illegal = 1'b0;
    case (op)
      OP_ADD:  r.result = a + b;
      OP_SUB:  r.result = a - b;
      OP_AND:  r.result = a & b;
      OP_OR:   r.result = a | b;
      OP_NOR:  r.result = ~(a | b);
      OP_XOR:  r.result = a ^ b;
      OP_SLL:  r.result = b << sh;
      OP_SRL:  r.result = b >> sh;
      OP_SLT:  r.result = (sa < sb) ? 32'd1 : 32'd0;
      OP_JR:   r.result = a;
      OP_BEQ:  begin r.result = a - b; r.branch = (a == b);      end
      OP_BNE:  begin r.result = a - b; r.branch = (a != b);      end
      OP_BGTZ: begin r.result = a - b; r.branch = (sa > 0);      end
      OP_BLEZ: begin r.result = a - b; r.branch = (sa <= 0);     end
      OP_REGIMM: begin
        r.result = a - b;
        // rt field selects BLTZ/BGEZ; other rt values never branch.
        if (b[4:0] == RT_BLTZ)      r.branch = sa[31];
        else if (b[4:0] == RT_BGEZ) r.branch = !sa[31];
      end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_branch;
  logic        r_illegal;
  logic        w_accept;
  logic        w_is_mul;
  logic        w_mul_done;
  logic [31:0] w_mul_p;
  alu_out_t    w_alu;

  assign InReady  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && OutReady);
  assign w_accept = InValid && InReady;
  assign w_is_mul = (ALUControl == OP_MUL);
  assign w_alu    = alu_op(ALUControl, A, B, Shamt);

  mult_iter u_mult (
    .Clk   (Clk),
    .Reset (Reset),
    .start (w_accept && w_is_mul),
    .A     (A),
    .B     (B),
    .done  (w_mul_done),
    .P     (w_mul_p)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (w_mul_done) w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (w_accept)      w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
        else if (OutReady) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result registers hold their value whenever nothing new is loaded.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_result  <= 32'd0;
      r_zero    <= 1'b1;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result  <= w_alu.result;
      r_zero    <= (w_alu.result == 32'd0);
      r_branch  <= w_alu.branch;
      r_illegal <= w_alu.illegal;
    end else if (w_mul_done) begin
      r_result  <= w_mul_p;
      r_zero    <= (w_mul_p == 32'd0);
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  assign OutValid    = (r_state == ST_DONE);
  assign ALUResult   = r_result;
  assign Zero        = r_zero;
  assign BranchTaken = r_branch;
  assign Illegal     = r_illegal;

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Clk  input  1  rising-edge clock; only clock.
REQ-002 Reset  input  1  asynchronous, active-low reset.
REQ-003 InValid  input  1  operation request valid.
REQ-004 InReady  output  1  unit can accept an operation this cycle.
REQ-005 ALUControl  input  6  operation code from the ALU control decoder.
REQ-006 A  input  32  operand A (rs).
REQ-007 B  input  32  operand B (rt/immediate); for code 000001, B[4:0] = rt field.
REQ-008 Shamt  input  5  shift amount for SLL/SRL.
REQ-009 OutValid  output  1  result valid.
REQ-010 OutReady  input  1  consumer accepts result.
REQ-011 ALUResult  output  32  operation result.
REQ-012 Zero  output  1  ALUResult == 0.
REQ-013 BranchTaken  output  1  branch condition true.
REQ-014 Illegal  output  1  ALUControl code unsupported.

Function
REQ-015 Accept SHALL occur when InValid && InReady; A, B, Shamt and ALUControl SHALL be captured at that edge.
REQ-016 InReady SHALL = (state==IDLE) || (state==DONE && OutReady), allowing back-to-back accepts.
REQ-017 FSM SHALL have states IDLE, MUL, DONE: IDLE->DONE on accept of a non-MUL code; IDLE->MUL on accept of 011000; MUL->DONE after 32 iterations; DONE->IDLE on OutReady with no accept; DONE->DONE or DONE->MUL on a simultaneous OutReady and accept.
REQ-018 Non-MUL latency SHALL be 1 cycle: OutValid is high in the cycle after accept.
REQ-019 MUL latency SHALL be 33 cycles, computed by iterative shift-add, 1 bit per cycle; result = low 32 bits of A*B, which is identical for signed and unsigned operands.
REQ-020 Codes SHALL map as follows:
- 100000 A+B
- 100010 A-B
- 100100 A&B
- 100101 A|B
- 100111 ~(A|B)
- 100110 A^B
- 000000 B<<Shamt
- 000010 B>>Shamt, logical
- 101010 signed A<B ? 1 : 0
- 001000 A (JR)
REQ-021 Adds and subtracts SHALL wrap modulo 2^32; no overflow flag.
REQ-022 Branch codes SHALL set ALUResult = A-B and BranchTaken as follows:
- 000100 A==B
- 000101 A!=B
- 000111 signed A>0
- 000110 signed A<=0
- 000001 with B[4:0]==0: A<0
- 000001 with B[4:0]==1: A>=0
REQ-023 BranchTaken SHALL be 0 for all non-branch codes.
REQ-024 Any other code, including 000011, SHALL give ALUResult=0, BranchTaken=0, Illegal=1, with 1-cycle latency.
REQ-025 ALUResult, Zero, BranchTaken and Illegal SHALL be registered and held stable while OutValid && !OutReady.
REQ-026 OutValid SHALL deassert on OutReady unless a new non-MUL operation is accepted in the same cycle.
REQ-027 InValid during MUL SHALL be ignored (InReady=0); no operation is dropped or duplicated.

Reset
REQ-028 Reset low SHALL immediately force state=IDLE, OutValid=0, ALUResult=0, Zero=1, BranchTaken=0, Illegal=0, iteration counter=0.
REQ-029 Reset mid-MUL SHALL abort the operation; no result is produced after release.
REQ-030 InReady SHALL be 1 in the first cycle after reset release.

Structure
REQ-031 Package alu_exec_pkg SHALL hold the 6-bit operation-code constants (shared with the ALU control decoder) and the FSM state encoding.
REQ-032 The iterative multiplier SHALL be sub-module mult_iter with ports start, done, A, B, and a 32-bit product low word.
REQ-033 The design SHALL use no divider or hard multiplier primitive.

Verification
REQ-034 ADD: A=0x7FFFFFFF, B=1, code 100000 -> next cycle OutValid=1, ALUResult=0x80000000, Zero=0.
REQ-035 MUL: A=0xFFFFFFFF (-1), B=5, code 011000 -> InReady=0 for 32 cycles, OutValid at accept+33, ALUResult=0xFFFFFFFB.
REQ-036 Branch: code 000001, A=0x80000000, B=0 -> BranchTaken=1; same A with B=1 -> BranchTaken=0; code 000100, A=B=7 -> BranchTaken=1, Zero=1.
REQ-037 Backpressure: SUB A=3, B=3 with OutReady=0 for 5 cycles -> OutValid and ALUResult=0 held stable; back-to-back AND accepted in the cycle OutReady=1.
REQ-038 Reset low at MUL iteration 10 -> OutValid=0 immediately; after release InReady=1 and no spurious result appears.
REQ-039 Illegal code 111111 -> 1 cycle later Illegal=1, ALUResult=0, BranchTaken=0.
